// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
// Bit/entry e of each table describes element Me.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic {
        OP_R,
        OP_W
    } op_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // Tables are padded to 8 entries so a 3-bit index never runs off the end.
    localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_RD_POL = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_POL = 8'b0000_1010;

    localparam logic [1:0] ELEM_NOPS [8] = '{
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1
    };

    localparam logic [63:0] CHECKER_WORD = {8{8'h55}};

endpackage

// File: rtl/sram_bist_checker.sv
// Read-data checker: delays expected word/address/element by RD_LAT,
// compares every macro, keeps sticky fail flags and the first failure.
module sram_bist_checker
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int NUM_MACROS = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_vld,
    input  logic [DATA_W-1:0]            i_exp,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [2:0]                   i_elem,
    input  logic [NUM_MACROS*DATA_W-1:0] i_q,
    output logic [NUM_MACROS-1:0]        o_fail_map,
    output logic [ADDR_W-1:0]            o_fail_addr,
    output logic [2:0]                   o_fail_elem
);

    logic [RD_LAT-1:0]     r_vld;
    logic [DATA_W-1:0]     r_exp  [RD_LAT];
    logic [ADDR_W-1:0]     r_addr [RD_LAT];
    logic [2:0]            r_elem [RD_LAT];
    logic [NUM_MACROS-1:0] r_map;
    logic [ADDR_W-1:0]     r_faddr;
    logic [2:0]            r_felem;
    logic [NUM_MACROS-1:0] w_mis;

    always_comb begin
        w_mis = '0;
        for (int i = 0; i < NUM_MACROS; i++) begin
            w_mis[i] = r_vld[RD_LAT-1] &&
                (i_q[i*DATA_W +: DATA_W] != r_exp[RD_LAT-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_vld   <= '0;
            r_map   <= '0;
            r_faddr <= '0;
            r_felem <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_exp[i]  <= '0;
                r_addr[i] <= '0;
                r_elem[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_exp[0]  <= i_exp;
            r_addr[0] <= i_addr;
            r_elem[0] <= i_elem;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_exp[i]  <= r_exp[i-1];
                r_addr[i] <= r_addr[i-1];
                r_elem[i] <= r_elem[i-1];
            end
            r_map <= r_map | w_mis;
            // An empty map means no failure has been seen yet this run.
            if (r_map == '0 && w_mis != '0) begin
                r_faddr <= r_addr[RD_LAT-1];
                r_felem <= r_elem[RD_LAT-1];
            end
        end
    end

    assign o_fail_map  = r_map;
    assign o_fail_addr = r_faddr;
    assign o_fail_elem = r_felem;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller driving NUM_MACROS SRAM macros from one shared
// bus; one op per cycle, drain for RD_LAT cycles, then report.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int NUM_MACROS = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bg_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [NUM_MACROS-1:0]        fail_map,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [2:0]                   fail_elem,
    output logic [NUM_MACROS-1:0]        sram_cen,
    output logic                         sram_gwen,
    output logic [DATA_W-1:0]            sram_wen,
    output logic [ADDR_W-1:0]            sram_a,
    output logic [DATA_W-1:0]            sram_d,
    input  logic [NUM_MACROS*DATA_W-1:0] sram_q
);

    state_t            r_state, w_nxt_state;
    logic [2:0]        r_elem, w_nxt_elem;
    logic [ADDR_W-1:0] r_addr, w_nxt_addr;
    logic              r_phase, w_nxt_phase;
    logic [1:0]        r_drn, w_nxt_drn;
    logic              r_bg, w_nxt_bg;

    logic              w_clear;
    logic              w_run;
    op_t               w_op;
    logic              w_last_op;
    logic              w_last_addr;
    logic [2:0]        w_inc;
    logic [DATA_W-1:0] w_d0;
    logic [DATA_W-1:0] w_val;

    assign w_run = (r_state == S_RUN);
    assign w_inc = r_elem + 3'd1;

    always_comb begin
        w_d0 = '0;
        if (r_bg) begin
            w_d0 = CHECKER_WORD[DATA_W-1:0] ^ {DATA_W{r_addr[0]}};
        end
        w_op = (ELEM_HAS_RD[r_elem] && !r_phase) ? OP_R : OP_W;
        if (w_op == OP_R) begin
            w_val = ELEM_RD_POL[r_elem] ? ~w_d0 : w_d0;
        end else begin
            w_val = ELEM_WR_POL[r_elem] ? ~w_d0 : w_d0;
        end
        w_last_op = ({1'b0, r_phase} == ELEM_NOPS[r_elem] - 2'd1);
        w_last_addr = ELEM_DOWN[r_elem] ? (r_addr == '0) : (r_addr == '1);
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_elem  = r_elem;
        w_nxt_addr  = r_addr;
        w_nxt_phase = r_phase;
        w_nxt_drn   = r_drn;
        w_nxt_bg    = r_bg;
        w_clear     = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_nxt_state = S_RUN;
                    w_nxt_elem  = M0;
                    w_nxt_addr  = '0;
                    w_nxt_phase = 1'b0;
                    w_nxt_bg    = bg_sel;
                end
            end
            S_RUN: begin
                if (!w_last_op) begin
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_phase = 1'b0;
                    if (!w_last_addr) begin
                        w_nxt_addr = ELEM_DOWN[r_elem] ?
                            r_addr - 1'b1 : r_addr + 1'b1;
                    end else if (r_elem == M5) begin
                        w_nxt_state = S_DRAIN;
                        w_nxt_drn   = '0;
                    end else begin
                        w_nxt_elem = w_inc;
                        w_nxt_addr = ELEM_DOWN[w_inc] ? '1 : '0;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drn == 2'(RD_LAT - 1)) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_drn = r_drn + 2'd1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_elem  <= M0;
            r_addr  <= '0;
            r_phase <= 1'b0;
            r_drn   <= '0;
            r_bg    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_elem  <= w_nxt_elem;
            r_addr  <= w_nxt_addr;
            r_phase <= w_nxt_phase;
            r_drn   <= w_nxt_drn;
            r_bg    <= w_nxt_bg;
        end
    end

    assign sram_cen  = w_run ? '0 : '1;
    assign sram_gwen = !(w_run && w_op == OP_W);
    assign sram_wen  = (w_run && w_op == OP_W) ? '0 : '1;
    assign sram_a    = w_run ? r_addr : '0;
    assign sram_d    = w_run ? w_val : '0;

    sram_bist_checker #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_MACROS (NUM_MACROS),
        .RD_LAT     (RD_LAT)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_vld       (w_run && w_op == OP_R),
        .i_exp       (w_val),
        .i_addr      (r_addr),
        .i_elem      (r_elem),
        .i_q         (sram_q),
        .o_fail_map  (fail_map),
        .o_fail_addr (fail_addr),
        .o_fail_elem (fail_elem)
    );

    assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);
    assign pass = done && (fail_map == '0);

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (RD_LAT 1 and 3) on behavioural
// macros with injectable faults, checked against a March C- array model.
module tb_sram_march_bist;

    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int NM   = 2;
    localparam int N    = 8;
    localparam int NOPS = 10 * N;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic bg_sel;

    logic          busy [2];
    logic          done [2];
    logic          pass [2];
    logic [NM-1:0] fmap [2];
    logic [AW-1:0] faddr [2];
    logic [2:0]    felem [2];
    logic [NM-1:0] cen [2];
    logic          gwen [2];
    logic [DW-1:0] wen [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [NM*DW-1:0] q [2];

    logic [DW-1:0] mem [2][NM][N];
    logic [DW-1:0] qraw [2][NM];
    logic [DW-1:0] q3a [NM];
    logic [DW-1:0] q3b [NM];
    logic [DW-1:0] rm [NM][N];

    int f_kind;
    int f_m;
    int f_a;
    int f_b;
    int f_vic;
    logic f_sv;

    typedef struct packed {
        logic          wr;
        logic [2:0]    el;
        logic [AW-1:0] ad;
        logic [DW-1:0] v;
    } op_s;

    op_s exp_q[$];
    logic [NM-1:0] e_map;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_elem;

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    sram_march_bist #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_MACROS(NM), .RD_LAT(1)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .bg_sel(bg_sel),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_map(fmap[0]), .fail_addr(faddr[0]), .fail_elem(felem[0]),
        .sram_cen(cen[0]), .sram_gwen(gwen[0]), .sram_wen(wen[0]),
        .sram_a(a[0]), .sram_d(d[0]), .sram_q(q[0])
    );

    sram_march_bist #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_MACROS(NM), .RD_LAT(3)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .bg_sel(bg_sel),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_map(fmap[1]), .fail_addr(faddr[1]), .fail_elem(felem[1]),
        .sram_cen(cen[1]), .sram_gwen(gwen[1]), .sram_wen(wen[1]),
        .sram_a(a[1]), .sram_d(d[1]), .sram_q(q[1])
    );

    function automatic logic [DW-1:0] fix(int m, int ad, logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (f_kind == 1 && m == f_m && ad == f_a) r[f_b] = f_sv;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int dd = 0; dd < 2; dd++) begin
            for (int mm = 0; mm < NM; mm++) begin
                if (cen[dd][mm] == 1'b0) begin
                    if (gwen[dd] == 1'b0) begin
                        mem[dd][mm][a[dd]] <= fix(mm, int'(a[dd]),
                            (mem[dd][mm][a[dd]] & wen[dd]) | (d[dd] & ~wen[dd]));
                        if (f_kind == 2 && mm == f_m && int'(a[dd]) == f_a)
                            mem[dd][mm][f_vic] <= ~mem[dd][mm][f_vic];
                    end else begin
                        qraw[dd][mm] <= mem[dd][mm][a[dd]];
                    end
                end
            end
        end
        q3a <= qraw[1];
        q3b <= q3a;
    end

    assign q[0] = {qraw[0][1], qraw[0][0]};
    assign q[1] = {q3b[1], q3b[0]};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bgd0(logic bg, int ad);
        if (!bg) return 8'h00;
        return (ad % 2 == 1) ? 8'hAA : 8'h55;
    endfunction

    task automatic build_ref(input logic bg);
        logic down, has_rd, has_wr, rpol, wpol;
        int ad;
        logic first;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            down   = (e == 3 || e == 4);
            has_rd = (e != 0);
            has_wr = (e != 5);
            rpol   = (e == 2 || e == 4);
            wpol   = (e == 1 || e == 3);
            for (int i = 0; i < N; i++) begin
                ad = down ? N - 1 - i : i;
                if (has_rd)
                    exp_q.push_back({1'b0, 3'(e), AW'(ad),
                        rpol ? ~bgd0(bg, ad) : bgd0(bg, ad)});
                if (has_wr)
                    exp_q.push_back({1'b1, 3'(e), AW'(ad),
                        wpol ? ~bgd0(bg, ad) : bgd0(bg, ad)});
            end
        end
        for (int m = 0; m < NM; m++)
            for (int i = 0; i < N; i++) rm[m][i] = '0;
        e_map = '0; e_addr = '0; e_elem = '0;
        first = 1'b1;
        foreach (exp_q[k]) begin
            for (int m = 0; m < NM; m++) begin
                if (exp_q[k].wr) begin
                    rm[m][exp_q[k].ad] = fix(m, int'(exp_q[k].ad), exp_q[k].v);
                    if (f_kind == 2 && m == f_m && int'(exp_q[k].ad) == f_a)
                        rm[m][f_vic] = ~rm[m][f_vic];
                end else if (rm[m][exp_q[k].ad] != exp_q[k].v) begin
                    e_map[m] = 1'b1;
                    if (first) begin
                        e_addr = exp_q[k].ad;
                        e_elem = exp_q[k].el;
                        first  = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_bus(input int k);
        logic [21:0] g, x;
        for (int dd = 0; dd < 2; dd++) begin
            g = {cen[dd], gwen[dd], wen[dd], a[dd],
                 gwen[dd] ? 8'h00 : d[dd]};
            if (exp_q[k].wr) x = {2'b00, 1'b0, 8'h00, exp_q[k].ad, exp_q[k].v};
            else             x = {2'b00, 1'b1, 8'hFF, exp_q[k].ad, 8'h00};
            check($sformatf("bus%0d_op%0d", dd, k), 32'(g), 32'(x));
        end
    endtask

    task automatic run(input logic bg, input bit glitch);
        int c0, c1;
        build_ref(bg);
        @(negedge clk);
        start = 1'b1; bg_sel = bg;
        @(negedge clk);
        start = 1'b0; bg_sel = 1'($urandom);
        check("busy_c1", {busy[0], busy[1], done[0], done[1]}, 4'b1100);
        for (int k = 0; k < NOPS; k++) begin
            if (k > 0) @(negedge clk);
            check_bus(k);
            start = (glitch && k == 40);
        end
        c0 = 0; c1 = 0;
        for (int c = NOPS + 1; c <= NOPS + 12 && (c0 == 0 || c1 == 0); c++) begin
            @(negedge clk);
            if (c == NOPS + 1) check("drain_cen", {cen[0], cen[1]}, 4'hF);
            if (done[0] && c0 == 0) c0 = c;
            if (done[1] && c1 == 0) c1 = c;
        end
        check("done_cyc0", c0, NOPS + 2);
        check("done_cyc1", c1, NOPS + 4);
        repeat (2) @(negedge clk);
        for (int dd = 0; dd < 2; dd++) begin
            check($sformatf("pass%0d", dd), {busy[dd], done[dd], pass[dd]},
                  {2'b01, e_map == '0});
            check($sformatf("fmap%0d", dd), fmap[dd], e_map);
            check($sformatf("faddr%0d", dd), faddr[dd], e_addr);
            check($sformatf("felem%0d", dd), felem[dd], e_elem);
        end
    endtask

    task automatic reset_check(input string tag);
        for (int dd = 0; dd < 2; dd++) begin
            check($sformatf("%s_st%0d", tag, dd),
                  {busy[dd], done[dd], pass[dd], fmap[dd], faddr[dd], felem[dd]},
                  0);
            check($sformatf("%s_bus%0d", tag, dd),
                  {cen[dd], gwen[dd], wen[dd], a[dd], d[dd]},
                  {2'b11, 1'b1, 8'hFF, 3'd0, 8'h00});
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        f_kind = 0; f_m = 0; f_a = 0; f_b = 0; f_vic = 1; f_sv = 1'b0;
        rst = 1'b1; start = 1'b0; bg_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst = 1'b0;

        run(1'b0, 1'b0);
        run(1'b1, 1'b0);

        f_kind = 1; f_m = 1; f_a = 5; f_b = 3; f_sv = 1'b1;
        run(1'b0, 1'b0);
        check("sa_map", e_map, 2'b10);

        f_kind = 2; f_m = 0; f_a = 2; f_vic = 6;
        run(1'($urandom), 1'b1);

        f_kind = 0;
        build_ref(1'b0);
        @(negedge clk);
        start = 1'b1; bg_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_check("midrst");
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            f_kind = int'($urandom_range(0, 2));
            f_m    = int'($urandom_range(0, NM - 1));
            f_a    = int'($urandom_range(0, N - 1));
            f_b    = int'($urandom_range(0, DW - 1));
            f_sv   = 1'($urandom);
            f_vic  = (f_a + int'($urandom_range(1, N - 1))) % N;
            run(1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
